// File: rtl/fp_accum.sv
// Multi-cycle float32 frame accumulator: IDLE -> ALIGN -> ADD -> NORM -> ROUND, one sample per pass.
// Define FP_ACCUM_RNE_EN for round-to-nearest-even in ROUND; otherwise results are truncated.
module fp_accum #(
    parameter int unsigned ACC_LEN = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    output logic [31:0] acc_out,
    output logic        ovf
);
    localparam logic [31:0]      QNAN = 32'h7FC00000;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);

    typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StRound} state_e;

    state_e           state;
    logic             ready;
    logic [31:0]      acc;
    logic [31:0]      x;
    logic [CNT_W-1:0] cnt;

    logic               spec_q;
    logic [31:0]        spec_val_q;
    logic               sign_q;
    logic               eff_sub_q;
    logic [7:0]         exp_a_q;
    logic [26:0]        sig_a_q;
    logic [26:0]        sig_b_q;
    logic [27:0]        sum_q;
    logic               zero_q;
    logic signed [9:0]  nexp_q;
    logic [26:0]        nmant_q;

    assign in_ready = ready;

    // ALIGN: specials, magnitude swap, exponent alignment of the smaller operand.
    logic        acc_nan, acc_inf, x_nan, x_inf;
    logic        al_spec;
    logic [31:0] al_spec_val;
    logic [30:0] mag_acc, mag_x;
    logic [31:0] op_a, op_b;
    logic [7:0]  ea, eb, d;
    logic [26:0] sa, sb, sb_sh, lost_mask;

    always_comb begin
        acc_nan = (acc[30:23] == 8'hFF) && (acc[22:0] != 23'h0);
        acc_inf = (acc[30:23] == 8'hFF) && (acc[22:0] == 23'h0);
        x_nan   = (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
        x_inf   = (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);

        al_spec     = 1'b0;
        al_spec_val = 32'h0;
        if (acc_nan || x_nan || (acc_inf && x_inf && (acc[31] != x[31]))) begin
            al_spec     = 1'b1;
            al_spec_val = QNAN;
        end else if (acc_inf) begin
            al_spec     = 1'b1;
            al_spec_val = {acc[31], 8'hFF, 23'h0};
        end else if (x_inf) begin
            al_spec     = 1'b1;
            al_spec_val = {x[31], 8'hFF, 23'h0};
        end

        // Denormals flush to zero before the magnitude compare.
        mag_acc = (acc[30:23] == 8'h0) ? 31'h0 : acc[30:0];
        mag_x   = (x[30:23] == 8'h0) ? 31'h0 : x[30:0];
        if (mag_x > mag_acc) begin
            op_a = {x[31], mag_x};
            op_b = {acc[31], mag_acc};
        end else begin
            op_a = {acc[31], mag_acc};
            op_b = {x[31], mag_x};
        end

        ea = op_a[30:23];
        eb = op_b[30:23];
        sa = (ea != 8'h0) ? {1'b1, op_a[22:0], 3'b000} : 27'h0;
        sb = (eb != 8'h0) ? {1'b1, op_b[22:0], 3'b000} : 27'h0;
        d  = ea - eb;

        lost_mask = 27'h0;
        if (d >= 8'd27) begin
            sb_sh = {26'h0, |sb};
        end else begin
            lost_mask = (27'h1 << d) - 27'h1;
            sb_sh     = (sb >> d) | {26'h0, |(sb & lost_mask)};
        end
    end

    // ADD: a >= b in magnitude, so the subtraction never goes negative.
    logic [27:0] add_sum;
    always_comb begin
        if (eff_sub_q) begin
            add_sum = {1'b0, sig_a_q} - {1'b0, sig_b_q};
        end else begin
            add_sum = {1'b0, sig_a_q} + {1'b0, sig_b_q};
        end
    end

    // NORM: carry-out shifts right keeping sticky; otherwise leading-zero shift left.
    logic [4:0]        lzc;
    logic              nm_zero;
    logic [26:0]       nm_mant;
    logic signed [9:0] nm_exp;

    always_comb begin
        lzc = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (sum_q[i]) begin
                lzc = 5'(26 - i);
            end
        end
        nm_zero = (sum_q == 28'h0);
        if (sum_q[27]) begin
            nm_mant = {sum_q[27:2], sum_q[1] | sum_q[0]};
            nm_exp  = $signed({2'b00, exp_a_q}) + 10'sd1;
        end else begin
            nm_mant = sum_q[26:0] << lzc;
            nm_exp  = $signed({2'b00, exp_a_q}) - $signed({5'b00000, lzc});
        end
    end

    // ROUND: mantissa is nmant_q[26:3]; guard/round/sticky are nmant_q[2:0].
    logic [24:0]       rmant;
    logic signed [9:0] rexp;
    logic [31:0]       rd_val;
    logic              rd_ovf;

    always_comb begin
        rmant = {1'b0, nmant_q[26:3]};
        rexp  = nexp_q;
`ifdef FP_ACCUM_RNE_EN
        if (nmant_q[2] && (nmant_q[1] || nmant_q[0] || nmant_q[3])) begin
            rmant = rmant + 25'd1;
        end
        if (rmant[24]) begin
            rmant = rmant >> 1;
            rexp  = rexp + 10'sd1;
        end
`endif
        rd_ovf = 1'b0;
        if (spec_q) begin
            rd_val = spec_val_q;
        end else if (zero_q || (rexp <= 10'sd0)) begin
            rd_val = 32'h0;
        end else if (rexp >= 10'sd255) begin
            rd_val = {sign_q, 8'hFF, 23'h0};
            rd_ovf = 1'b1;
        end else begin
            rd_val = {sign_q, rexp[7:0], rmant[22:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            ready     <= 1'b1;
            acc       <= 32'h0;
            cnt       <= '0;
            acc_out   <= 32'h0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else if (clr) begin
            state     <= StIdle;
            ready     <= 1'b1;
            acc       <= 32'h0;
            cnt       <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            // ovf of a finished frame is shown alongside out_valid, then dropped.
            if (out_valid) begin
                ovf <= 1'b0;
            end
            unique case (state)
                StIdle: begin
                    if (in_valid && ready) begin
                        state <= StAlign;
                        ready <= 1'b0;
                    end
                end
                StAlign: state <= StAdd;
                StAdd:   state <= StNorm;
                StNorm:  state <= StRound;
                StRound: begin
                    state <= StIdle;
                    ready <= 1'b1;
                    if (rd_ovf) begin
                        ovf <= 1'b1;
                    end
                    if (cnt == LAST) begin
                        acc_out   <= rd_val;
                        out_valid <= 1'b1;
                        acc       <= 32'h0;
                        cnt       <= '0;
                    end else begin
                        acc <= rd_val;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= StIdle;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    // Datapath stage registers need no reset: the FSM alone decides what is consumed.
    always_ff @(posedge clk) begin
        case (state)
            StIdle: begin
                if (in_valid && ready) begin
                    x <= in_data;
                end
            end
            StAlign: begin
                spec_q     <= al_spec;
                spec_val_q <= al_spec_val;
                sign_q     <= op_a[31];
                eff_sub_q  <= op_a[31] ^ op_b[31];
                exp_a_q    <= ea;
                sig_a_q    <= sa;
                sig_b_q    <= sb_sh;
            end
            StAdd: begin
                sum_q <= add_sum;
            end
            StNorm: begin
                zero_q  <= nm_zero;
                nmant_q <= nm_mant;
                nexp_q  <= nm_exp;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fp_accum.sv
// Scoreboard bench for fp_accum (ACC_LEN=4): expected frame sums are queued as frames are driven
// and compared against each out_valid pulse, including its cycle of arrival.
module tb_fp_accum;
    localparam int unsigned ACC_LEN = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] acc_out;
    logic        ovf;

    fp_accum #(
        .ACC_LEN(ACC_LEN),
        .CNT_W  (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .acc_out  (acc_out),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sum;
        logic        ovf;
        int          cyc;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    sb_entry_t e;
    int        n_checks = 0;
    int        n_errors = 0;
    int        cyc = 0;
    int        acc_cyc = 0;
    logic      prev_ov = 1'b0;

`ifdef FP_ACCUM_RNE_EN
    localparam logic [31:0] ALIGN_SUM = 32'h3F800001;
`else
    localparam logic [31:0] ALIGN_SUM = 32'h3F800000;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Out_valid is visible in the cycle ending at edge t+5, i.e. 4 edges after the accept edge t.
    task automatic expect_frame(input logic [31:0] sum, input logic ov);
        sb_entry_t n;
        n.sum = sum;
        n.ovf = ov;
        n.cyc = acc_cyc + 4;
        sb_q.push_back(n);
    endtask

    task automatic send(input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", {31'b0, in_ready}, 32'h1);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                              input logic [31:0] d, input logic [31:0] sum, input logic ov);
        send(a);
        send(b);
        send(c);
        send(d);
        expect_frame(sum, ov);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_ov) check("ovf_clear", {31'b0, ovf}, 32'h0);
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out_valid", {31'b0, out_valid}, 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    check("acc_out", acc_out, e.sum);
                    check("ovf_at_out", {31'b0, ovf}, {31'b0, e.ovf});
                    check("latency", 32'(cyc), 32'(e.cyc));
                end
            end
            prev_ov <= out_valid;
        end else begin
            prev_ov <= 1'b0;
        end
    end

    initial begin
        int n;
        int c0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_ready", {31'b0, in_ready}, 32'h1);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_acc_out", acc_out, 32'h0);
        check("rst_ovf", {31'b0, ovf}, 32'h0);

        send_frame(32'h3F800000, 32'h40000000, 32'h3F000000, 32'hBE800000, 32'h40500000, 1'b0);
        send_frame(32'h40A00000, 32'hC0A00000, 32'h00000000, 32'h00000001, 32'h00000000, 1'b0);
        send_frame(32'h3F800000, 32'h33C00000, 32'h0, 32'h0, ALIGN_SUM, 1'b0);

        // Overflow frame: ovf rises with the second write and stays sticky.
        send(32'h7F7FFFFF);
        repeat (4) @(negedge clk);
        check("ovf_first_write", {31'b0, ovf}, 32'h0);
        send(32'h7F7FFFFF);
        repeat (4) @(negedge clk);
        check("ovf_second_write", {31'b0, ovf}, 32'h1);
        send(32'h0);
        send(32'h0);
        expect_frame(32'h7F800000, 1'b1);

        send_frame(32'h7FC00001, 32'h3F800000, 32'h0, 32'h0, 32'h7FC00000, 1'b0);

        // in_valid held high: one accept per 5 cycles, data taken only at the handshake.
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        c0 = cyc;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("ready_pattern", {31'b0, in_ready}, (i % 5 == 0) ? 32'h1 : 32'h0);
            in_data = (i % 5 == 0) ? 32'h3F800000 : $urandom;
            if (i == 15) begin
                acc_cyc = c0 + 16;
                expect_frame(32'h40800000, 1'b0);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;

        // clr while the third sample is in ADD; a sample offered alongside is ignored.
        send(32'h41000000);
        send(32'h41000000);
        send(32'h41000000);
        @(negedge clk);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h42C80000;
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        check("clr_ready", {31'b0, in_ready}, 32'h1);
        clr      = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        check("clr_no_accept", {31'b0, in_ready}, 32'h1);
        check("clr_acc_out_kept", acc_out, 32'h40800000);
        send_frame(32'h3F800000, 32'h40000000, 32'h3F000000, 32'hBE800000, 32'h40500000, 1'b0);

        // Reset while the last sample of an overflowing frame sits in NORM.
        send(32'h7F7FFFFF);
        send(32'h7F7FFFFF);
        send(32'h0);
        send(32'h3F800000);
        @(negedge clk);
        @(negedge clk);
        check("ovf_before_reset", {31'b0, ovf}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_ready", {31'b0, in_ready}, 32'h1);
        check("mid_rst_acc_out", acc_out, 32'h0);
        check("mid_rst_ovf", {31'b0, ovf}, 32'h0);
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'h0);
        repeat (8) @(negedge clk);
        check("post_rst_ready", {31'b0, in_ready}, 32'h1);
        send_frame(32'h40A00000, 32'h3F800000, 32'h3F800000, 32'h3F000000, 32'h40F00000, 1'b0);

        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb_q.size()), 32'h0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
